// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the divide request sequencer:
//   - default parameter constants (operand width, FIFO depth, tag width)
//   - sequencer FSM state enum
//   - request record layout. The FIFO payload in div_sequencer is packed in
//     the same field order, so at default parameters a FIFO word can be cast
//     straight to req_t.
// -----------------------------------------------------------------------------
package div_seq_pkg;

  localparam int P_PARALLELISM = 32;
  localparam int P_DEPTH       = 4;
  localparam int P_TAG_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic                     usigned;
    logic                     rem;
    logic [P_PARALLELISM-1:0] dividend;
    logic [P_PARALLELISM-1:0] divisor;
    logic [P_TAG_W-1:0]       tag;
  } req_t;

endpackage

// File: rtl/div_req_fifo.sv
// -----------------------------------------------------------------------------
// div_req_fifo
// Small synchronous first-word-fall-through FIFO holding queued divide
// requests. o_data always shows the head entry while o_empty is low.
//
// Parameters:
//   DEPTH  number of entries (power of 2, >= 2)
//   W      payload width
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_data (ignored while full)
//   i_data       payload to write
//   i_pop        drop head entry (ignored while empty)
//   o_data       head entry
//   o_full       no free entry
//   o_empty      no stored entry
// -----------------------------------------------------------------------------
module div_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bits means full.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Front-end for DivisorUnit. Requests are queued in div_req_fifo, issued one
// at a time to the divider with a single-cycle valid pulse, and the selected
// quotient or remainder is returned with the request tag.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready depends only on registered FIFO state; rsp_valid
// stays high with stable rsp_data/rsp_tag until rsp_ready is seen.
//
// Optional build macro: DIV_ZERO_BYPASS_EN
//   defined   - a popped request with divisor==0 skips the divider and answers
//               quotient = all ones, remainder = dividend.
//   undefined - divide-by-zero is issued to the divider like any request.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_usigned, req_rem       1=unsigned; 1=return remainder
//   req_dividend, req_divisor  operands
//   req_tag                    returned unchanged with the response
//   valid                      one-cycle launch pulse to DivisorUnit
//   usigned, dividend, divisor operands to DivisorUnit (held during divide)
//   quotient, reminder         results from DivisorUnit
//   res_ready                  DivisorUnit done; its rising edge is used
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_tag          selected result and its tag
//   dbg_state                  current FSM state
// -----------------------------------------------------------------------------
module div_sequencer
  import div_seq_pkg::*;
#(
  parameter int parallelism = P_PARALLELISM,
  parameter int DEPTH       = P_DEPTH,
  parameter int TAG_W       = P_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_usigned,
  input  logic                   req_rem,
  input  logic [parallelism-1:0] req_dividend,
  input  logic [parallelism-1:0] req_divisor,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   valid,
  output logic                   usigned,
  output logic [parallelism-1:0] dividend,
  output logic [parallelism-1:0] divisor,
  input  logic [parallelism-1:0] quotient,
  input  logic [parallelism-1:0] reminder,
  input  logic                   res_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [parallelism-1:0] rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output state_e                 dbg_state
);

  localparam int PW = 2 + 2 * parallelism + TAG_W;

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  logic [PW-1:0] w_push_data;
  logic [PW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign req_ready   = !w_full;
  assign w_push      = req_valid && !w_full;
  assign w_push_data = {req_usigned, req_rem, req_dividend, req_divisor, req_tag};

  div_req_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  logic                   w_h_usigned;
  logic                   w_h_rem;
  logic [parallelism-1:0] w_h_dividend;
  logic [parallelism-1:0] w_h_divisor;
  logic [TAG_W-1:0]       w_h_tag;

  assign {w_h_usigned, w_h_rem, w_h_dividend, w_h_divisor, w_h_tag} = w_head;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e                 r_state;
  state_e                 w_next;
  logic                   r_usigned;
  logic                   r_rem;
  logic [parallelism-1:0] r_dividend;
  logic [parallelism-1:0] r_divisor;
  logic [TAG_W-1:0]       r_tag;
  logic [parallelism-1:0] r_rsp_data;
  logic [TAG_W-1:0]       r_rsp_tag;
  logic                   r_res_ready_q;

  logic w_res_rise;
  logic w_capture;
  logic w_head_div0;
  logic w_bypass;

  // Only a fresh rising edge counts, so a done level left over from the
  // previous divide (or raised during LAUNCH) cannot complete this one.
  assign w_res_rise = res_ready && !r_res_ready_q;

`ifdef DIV_ZERO_BYPASS_EN
  assign w_head_div0 = (w_h_divisor == '0);
`else
  assign w_head_div0 = 1'b0;
`endif

  assign w_bypass = w_pop && w_head_div0;

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = w_head_div0 ? RESP : LAUNCH;
        end
      end
      LAUNCH: begin
        w_next = WAIT;
      end
      WAIT: begin
        if (w_res_rise) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_usigned     <= 1'b0;
      r_rem         <= 1'b0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_tag         <= '0;
      r_rsp_data    <= '0;
      r_rsp_tag     <= '0;
      r_res_ready_q <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_res_ready_q <= res_ready;
      // Operands only move when a request leaves the queue, so they stay
      // stable for the whole divide.
      if (w_pop) begin
        r_usigned  <= w_h_usigned;
        r_rem      <= w_h_rem;
        r_dividend <= w_h_dividend;
        r_divisor  <= w_h_divisor;
        r_tag      <= w_h_tag;
      end
      if (w_bypass) begin
        r_rsp_data <= w_h_rem ? w_h_dividend : '1;
        r_rsp_tag  <= w_h_tag;
      end else if (w_capture) begin
        r_rsp_data <= r_rem ? reminder : quotient;
        r_rsp_tag  <= r_tag;
      end
    end
  end

  assign valid     = (r_state == LAUNCH);
  assign rsp_valid = (r_state == RESP);
  assign usigned   = r_usigned;
  assign dividend  = r_dividend;
  assign divisor   = r_divisor;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;
  assign dbg_state = r_state;

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Front-end sequencer placed directly upstream of DivisorUnit. It accepts divide/remainder requests from the core over a valid/ready interface and buffers them in a small FIFO. It issues each request to DivisorUnit as a one-cycle valid pulse, holds the operands stable for the whole divide, and waits for res_ready. It then returns the selected quotient or remainder, tagged, over a valid/ready response interface.

Parameters:
parallelism, 32, operand/result width (matches DivisorUnit)
DEPTH, 4, request FIFO entries (power of 2, >=2)
TAG_W, 4, request tag width, returned unchanged with the result

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  request FIFO not full
req_usigned  in  1  1=unsigned, 0=signed
req_rem  in  1  1=return remainder, 0=return quotient
req_dividend  in  parallelism  dividend
req_divisor  in  parallelism  divisor
req_tag  in  TAG_W  request tag
valid  out  1  to DivisorUnit.valid; one-cycle launch pulse
usigned  out  1  to DivisorUnit.usigned
dividend  out  parallelism  to DivisorUnit.dividend
divisor  out  parallelism  to DivisorUnit.divisor
quotient  in  parallelism  from DivisorUnit
reminder  in  parallelism  from DivisorUnit
res_ready  in  1  from DivisorUnit, result-done indication
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  parallelism  quotient or remainder, per req_rem
rsp_tag  out  TAG_W  tag of the answered request

Behaviour:
- Reset (async, rst_n=0) values:
  - FIFO empty; FSM in IDLE.
  - valid=0, rsp_valid=0; usigned/dividend/divisor/rsp_data/rsp_tag=0.
  - res_ready edge register=0.
  - req_ready=1 from the first clock after reset release.
- FIFO:
  - Push when req_valid && req_ready.
  - req_ready = !full. It is registered-state based and never depends combinationally on req_valid.
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
  - Pop only by the FSM in IDLE.
  - Simultaneous push and pop are legal in any non-full state; count is unchanged.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop the head into the operand register (usigned/dividend/divisor plus the rem/tag side register) and go to LAUNCH. Otherwise stay.
  - LAUNCH: valid=1 for exactly this cycle. Next state is WAIT.
  - WAIT: operands held stable. On a rising edge of res_ready (res_ready=1 and the registered previous value=0), capture rsp_data = rem ? reminder : quotient, set rsp_tag, and go to RESP. A res_ready already high on entry to WAIT is ignored until it has dropped and risen again.
  - RESP: rsp_valid=1 and rsp_data/rsp_tag stable. When rsp_ready=1, rsp_valid drops next cycle and the FSM returns to IDLE.
- Only one request is in flight; capacity is DEPTH queued plus one in the operand register.
- Latency: a request pushed into an empty FIFO at edge N is popped at N+1, and valid is high in cycle N+1..N+2. The response appears 1 cycle after the res_ready rising edge. Minimum spacing between back-to-back launches is 4 cycles plus the divider time.
- Operand outputs change only when leaving IDLE. They are never X after reset.
- Reset mid-operation: all state is discarded and no response is produced. DivisorUnit shares rst_n.
- Width rule: no extension or truncation; values pass through at parallelism bits.

Optional Feature:
DIV_ZERO_BYPASS_EN
- Defined: if the popped divisor==0, go IDLE->RESP directly without pulsing valid.
  - quotient result = all ones.
  - remainder result = dividend.
  - This holds for signed and unsigned operation.
- Undefined: divide-by-zero goes through DivisorUnit like any other request, and the result is whatever the divider returns.

Decomposition:
- Package div_seq_pkg holds:
  - the FSM state enum (IDLE, LAUNCH, WAIT, RESP);
  - the request struct typedef (usigned, rem, dividend, divisor, tag);
  - the default-parameter constants.
- One sub-module, div_req_fifo (parameterised DEPTH and payload width), provides push/pop/full/empty. The FSM and capture logic stay in div_sequencer.

Test Plan:
- Unsigned, rem=0, 100/7, tag=3 -> exactly one valid pulse; rsp_data=14, rsp_tag=3.
- Same operands with rem=1 -> rsp_data=2.
- Signed -7/2, rem=0 -> rsp_data=0xFFFFFFFD; with rem=1 -> 0xFFFFFFFF.
- Backpressure:
  - Stimulus: hold rsp_ready=0; push 6 requests in consecutive cycles.
  - Required response: req_ready drops after the 5th accept (1 in flight + 4 queued), and no request is lost.
  - Required response: after releasing rsp_ready, the responses come out in push order with matching tags.
- Unsigned 0x9F5A87B0 / 0xADCC2209 -> quotient=0, remainder=0x9F5A87B0. Operands stay stable from the launch until res_ready rises.
- Divide-by-zero, unsigned 5/0:
  - With DIV_ZERO_BYPASS_EN: no valid pulse; quotient=0xFFFFFFFF, remainder=5.
  - Without it: one valid pulse, and the response follows res_ready.
- Assert rst_n=0 during WAIT -> valid and rsp_valid are 0 immediately and the FIFO is empty. After release there is no stale response, and a new request completes normally.
